// File: rtl/pipe_skid_stage_if.sv
// Fetch-to-decode handshake bundle for pipe_skid_stage.
// The stage uses the slave modport; the driving/observing side uses master.
interface pipe_skid_stage_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_pc4;
  logic [INST_W-1:0] out_inst;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_pc4, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_pc4, out_inst
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered IF/ID stage with load-use hold, jump flush and
// saturating stall/flush counters. Empty head presents NOP_INST.
module pipe_skid_stage #(
  parameter int                PC_W            = 32,
  parameter int                INST_W          = 32,
  parameter logic [INST_W-1:0] NOP_INST        = 32'h0000_0013,
  parameter bit                HOLD_OVER_FLUSH = 1'b1,
  parameter int                CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_skid_stage_if.slave   bus,
  input  logic               hold,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic              h_v, s_v;
  logic [PC_W-1:0]   h_pc, h_pc4, s_pc, s_pc4;
  logic [INST_W-1:0] h_inst, s_inst;

  logic              drain, acc, fl, stall_ev;
  logic [PC_W-1:0]   cap_pc4;

  // in_ready comes straight from the skid flop, so no path from out_ready/hold
  assign bus.in_ready = ~s_v;

  assign drain    = h_v & bus.out_ready & ~hold;
  assign acc      = bus.in_valid & ~s_v;
  assign fl       = HOLD_OVER_FLUSH ? (flush & ~hold) : flush;
  assign stall_ev = h_v & ~(bus.out_ready & ~hold);
  assign cap_pc4  = bus.in_pc + PC_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_v       <= 1'b0;
      s_v       <= 1'b0;
      h_pc      <= '0;
      h_pc4     <= '0;
      h_inst    <= NOP_INST;
      s_pc      <= '0;
      s_pc4     <= '0;
      s_inst    <= NOP_INST;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (fl) begin
        // a beat accepted this cycle is consumed upstream but dropped here
        h_v <= 1'b0;
        s_v <= 1'b0;
        if (flush_cnt != '1)
          flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (!h_v) begin
        if (acc) begin
          h_v    <= 1'b1;
          h_pc   <= bus.in_pc;
          h_pc4  <= cap_pc4;
          h_inst <= bus.in_inst;
        end
      end else if (drain) begin
        if (s_v) begin
          h_pc   <= s_pc;
          h_pc4  <= s_pc4;
          h_inst <= s_inst;
          s_v    <= 1'b0;
        end else if (acc) begin
          h_pc   <= bus.in_pc;
          h_pc4  <= cap_pc4;
          h_inst <= bus.in_inst;
        end else begin
          h_v <= 1'b0;
        end
      end else if (acc) begin
        s_v    <= 1'b1;
        s_pc   <= bus.in_pc;
        s_pc4  <= cap_pc4;
        s_inst <= bus.in_inst;
      end
    end
  end

  assign bus.out_valid = h_v;
  assign bus.out_pc    = h_v ? h_pc   : '0;
  assign bus.out_pc4   = h_v ? h_pc4  : '0;
  assign bus.out_inst  = h_v ? h_inst : NOP_INST;
  assign occupancy     = {1'b0, h_v} + {1'b0, s_v};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (hold-over-flush with 16-bit
// counters, flush-over-hold with 2-bit counters) against a FIFO model.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.PC_W(32), .INST_W(32)) if_a ();
  pipe_skid_stage_if #(.PC_W(32), .INST_W(32)) if_b ();

  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  stall_b, flush_b;

  pipe_skid_stage #(.HOLD_OVER_FLUSH(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .hold(hold), .flush(flush),
    .occupancy(occ_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipe_skid_stage #(.HOLD_OVER_FLUSH(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .hold(hold), .flush(flush),
    .occupancy(occ_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  // model: per instance, an ordered list of up to two {pc, inst} entries
  int          m_cnt  [2];
  logic [31:0] m_pc   [2][2];
  logic [31:0] m_inst [2][2];
  int          m_stall[2];
  int          m_flush[2];

  int n_assert = 0;
  int n_fail   = 0;

  logic        cur_iv, cur_ordy;
  logic [31:0] cur_pc, cur_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_stall[m] = 0; m_flush[m] = 0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int  cmax;
      bit  fl, drn, acc;
      cmax = (m == 0) ? 65535 : 3;
      fl   = (m == 0) ? (flush && !hold) : flush;
      drn  = (m_cnt[m] > 0) && cur_ordy && !hold;
      acc  = cur_iv && (m_cnt[m] < 2);
      if (m_cnt[m] > 0 && !(cur_ordy && !hold) && m_stall[m] < cmax)
        m_stall[m]++;
      if (fl) begin
        m_cnt[m] = 0;
        if (m_flush[m] < cmax) m_flush[m]++;
      end else begin
        if (drn) begin
          m_pc[m][0] = m_pc[m][1]; m_inst[m][0] = m_inst[m][1];
          m_cnt[m]--;
        end
        if (acc) begin
          m_pc[m][m_cnt[m]] = cur_pc; m_inst[m][m_cnt[m]] = cur_inst;
          m_cnt[m]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic [31:0] e_pc, e_pc4, e_inst;
      bit          v;
      v      = m_cnt[m] > 0;
      e_pc   = v ? m_pc[m][0] : 32'h0;
      e_pc4  = v ? m_pc[m][0] + 32'd4 : 32'h0;
      e_inst = v ? m_inst[m][0] : 32'h0000_0013;
      if (m == 0) begin
        chk({tag, ".a.out_valid"}, {31'b0, if_a.out_valid}, {31'b0, v});
        chk({tag, ".a.in_ready"},  {31'b0, if_a.in_ready},  {31'b0, m_cnt[m] < 2});
        chk({tag, ".a.out_pc"},    if_a.out_pc,   e_pc);
        chk({tag, ".a.out_pc4"},   if_a.out_pc4,  e_pc4);
        chk({tag, ".a.out_inst"},  if_a.out_inst, e_inst);
        chk({tag, ".a.occupancy"}, {30'b0, occ_a}, m_cnt[m]);
        chk({tag, ".a.stall_cnt"}, {16'b0, stall_a}, m_stall[m]);
        chk({tag, ".a.flush_cnt"}, {16'b0, flush_a}, m_flush[m]);
      end else begin
        chk({tag, ".b.out_valid"}, {31'b0, if_b.out_valid}, {31'b0, v});
        chk({tag, ".b.in_ready"},  {31'b0, if_b.in_ready},  {31'b0, m_cnt[m] < 2});
        chk({tag, ".b.out_pc"},    if_b.out_pc,   e_pc);
        chk({tag, ".b.out_pc4"},   if_b.out_pc4,  e_pc4);
        chk({tag, ".b.out_inst"},  if_b.out_inst, e_inst);
        chk({tag, ".b.occupancy"}, {30'b0, occ_b}, m_cnt[m]);
        chk({tag, ".b.stall_cnt"}, {30'b0, stall_b}, m_stall[m]);
        chk({tag, ".b.flush_cnt"}, {30'b0, flush_b}, m_flush[m]);
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic hld, input logic fls);
    cur_iv = iv; cur_pc = pc; cur_inst = inst; cur_ordy = ordy;
    if_a.in_valid = iv; if_a.in_pc = pc; if_a.in_inst = inst; if_a.out_ready = ordy;
    if_b.in_valid = iv; if_b.in_pc = pc; if_b.in_inst = inst; if_b.out_ready = ordy;
    hold = hld; flush = fls;
  endtask

  task automatic cyc(input string tag, input logic iv, input logic [31:0] pc,
                     input logic ordy, input logic hld, input logic fls);
    drive(iv, pc, pc ^ 32'hA5A5_0000, ordy, hld, fls);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1 check_all("reset_init");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // streaming
    cyc("stream0", 1, 32'h100, 1, 0, 0);
    cyc("stream1", 1, 32'h104, 1, 0, 0);
    cyc("stream2", 1, 32'h108, 1, 0, 0);
    cyc("stream3", 0, 32'h0,   1, 0, 0);

    // backpressure: fill head and skid, then drain in order
    cyc("bp0", 1, 32'h200, 0, 0, 0);
    cyc("bp1", 1, 32'h204, 0, 0, 0);
    cyc("bp2", 1, 32'h208, 0, 0, 0);
    cyc("bp3", 0, 32'h0,   1, 0, 0);
    cyc("bp4", 0, 32'h0,   1, 0, 0);
    cyc("bp5", 0, 32'h0,   1, 0, 0);

    // load-use hold
    cyc("lu0", 1, 32'h300, 1, 0, 0);
    cyc("lu1", 0, 32'h0,   1, 1, 0);
    cyc("lu2", 0, 32'h0,   1, 0, 0);

    // hold and flush together, then plain flush with a concurrent accept
    cyc("hf0", 1, 32'h400, 0, 0, 0);
    cyc("hf1", 0, 32'h0,   1, 1, 1);
    cyc("hf2", 1, 32'h404, 0, 0, 0);
    cyc("hf3", 1, 32'h408, 0, 0, 1);
    cyc("hf4", 0, 32'h0,   1, 0, 0);

    // PC+4 wraparound
    cyc("wrap0", 1, 32'hFFFF_FFFC, 1, 0, 0);
    cyc("wrap1", 0, 32'h0,         1, 0, 0);

    // counter saturation on the 2-bit instance
    cyc("sat0", 1, 32'h500, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("sat", 0, 32'h0, 0, 0, 0);
    chk("sat.b.stall_saturated", {30'b0, stall_b}, 32'd3);
    for (int i = 0; i < 4; i++) cyc("fsat", 0, 32'h0, 1, 0, 1);

    // reset mid-transfer: entries dropped as soon as rst rises
    cyc("mr0", 1, 32'h600, 0, 0, 0);
    cyc("mr1", 1, 32'h604, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("reset_async");
    for (int i = 0; i < 3; i++) cyc("reset_hold", 1, 32'h700, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_reset", 1, 32'h800, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          $urandom_range(0, 3) != 0,
          $urandom() & 32'hFFFF_FFFC,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
